// File: rtl/simple_dual_pipe.sv
// simple_dual_pipe: single-clock simple dual-port RAM.
// Port A writes with per-byte enables. Port B reads with a latency of 1 or 2
// cycles and a qualifying valid strobe. A sequencer clears memory after reset.
// Legal parameter values: WIDTH a multiple of 8, RD_LATENCY 1 or 2,
// COLL_MODE 0 (read-first) or 1 (write-first, merged per byte lane).
module simple_dual_pipe #(
    parameter int WIDTH         = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int RD_LATENCY    = 1,
    parameter int COLL_MODE     = 0,
    parameter int INIT_ON_RESET = 1,
    localparam int WEA_WIDTH    = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [WEA_WIDTH-1:0]  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [WIDTH-1:0]      dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [WIDTH-1:0]      doutb,
    output logic                  doutb_valid,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   init_addr_reg;
    logic                    init_busy_reg;

    // Clear sequencer: walk every address once, then hand the ports over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_addr_reg <= '0;
            init_busy_reg <= (INIT_ON_RESET != 0);
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_addr_reg <= init_addr_reg + ADDR_WIDTH'(1);
                    if (init_addr_reg == LAST_ADDR) begin
                        state_reg     <= ST_RUN;
                        init_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    init_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy = init_busy_reg;

    // Port qualification. Nothing is accepted while reset is asserted, and
    // the user ports are ignored until the clear sequence has finished.
    logic run;
    logic wr_run;
    logic rd_accept;
    logic coll;

    assign run       = rst_n && (state_reg == ST_RUN);
    assign wr_run    = run && ena;
    assign rd_accept = run && enb;
    assign coll      = wr_run && rd_accept && (addra == addrb);

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WEA_WIDTH-1:0]  wr_lane_en;
    logic [WIDTH-1:0]      wr_data;

    // Write-port mux: the sequencer owns the write port during the clear.
    always_comb begin
        wr_addr    = addra;
        wr_lane_en = '0;
        wr_data    = dina;
        if (rst_n && (state_reg == ST_INIT)) begin
            wr_addr    = init_addr_reg;
            wr_lane_en = '1;
            wr_data    = '0;
        end else if (wr_run) begin
            wr_lane_en = wea;
        end
    end

    // RAM output word, assembled from the independent byte-lane memories.
    logic [WIDTH-1:0] ram_q;

    // One narrow RAM per byte lane. This keeps byte enables a plain per-RAM
    // write enable, and lets the write-first merge be decided per lane.
    genvar gi;
    generate
        for (gi = 0; gi < WEA_WIDTH; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            // Byte-lane write port.
            always_ff @(posedge clk) begin
                if (wr_lane_en[gi]) begin
                    mem[wr_addr] <= wr_data[8*gi +: 8];
                end
            end

            // Registered read. The array read returns the pre-write byte, so
            // read-first needs nothing extra. Write-first forwards the
            // incoming byte of an enabled lane on a same-address collision.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (rd_accept) begin
                    if ((COLL_MODE == 1) && coll && wea[gi]) begin
                        q_reg <= dina[8*gi +: 8];
                    end else begin
                        q_reg <= mem[addrb];
                    end
                end
            end

            assign ram_q[8*gi +: 8] = q_reg;
        end
    endgenerate

    // Valid bit that travels alongside the RAM output register.
    logic ram_vld_reg;

    // Track which RAM output words carry an accepted read. Reset flushes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_vld_reg <= 1'b0;
        end else begin
            ram_vld_reg <= rd_accept;
        end
    end

    // First output stage. It only loads on a completing read, so doutb holds
    // its last value between reads.
    logic [WIDTH-1:0] dout1_reg;
    logic             vld1_reg;

    // Output stage 1: data and strobe for latency 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout1_reg <= '0;
            vld1_reg  <= 1'b0;
        end else begin
            vld1_reg <= ram_vld_reg;
            if (ram_vld_reg) begin
                dout1_reg <= ram_q;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] dout2_reg;
            logic             vld2_reg;

            // Extra output register stage for latency 2.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout2_reg <= '0;
                    vld2_reg  <= 1'b0;
                end else begin
                    vld2_reg <= vld1_reg;
                    if (vld1_reg) begin
                        dout2_reg <= dout1_reg;
                    end
                end
            end

            assign doutb       = dout2_reg;
            assign doutb_valid = vld2_reg;
        end else begin : g_lat1
            assign doutb       = dout1_reg;
            assign doutb_valid = vld1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_simple_dual_pipe.sv
// Directed testbench for simple_dual_pipe. Two instances share the stimulus:
// u_dut_a is latency 1 / read-first, u_dut_b is latency 2 / write-first.
// Expected values are written out by hand for each instance.
module tb_simple_dual_pipe;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  wea;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [3:0]  addrb;

    logic [31:0] doutb_a;
    logic        doutb_valid_a;
    logic        init_busy_a;
    logic [31:0] doutb_b;
    logic        doutb_valid_b;
    logic        init_busy_b;

    simple_dual_pipe #(
        .WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .COLL_MODE(0), .INIT_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_a), .doutb_valid(doutb_valid_a),
        .init_busy(init_busy_a)
    );

    simple_dual_pipe #(
        .WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .COLL_MODE(1), .INIT_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb_b), .doutb_valid(doutb_valid_b),
        .init_busy(init_busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    logic [31:0] got_a[$];
    logic [31:0] got_b[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          edge_a[$];
    int          edge_b[$];

    // Capture every valid read word, and the edge it appeared on.
    always @(posedge clk) begin
        #1;
        if (doutb_valid_a) begin
            got_a.push_back(doutb_a);
            edge_a.push_back(edge_cnt);
        end
        if (doutb_valid_b) begin
            got_b.push_back(doutb_b);
            edge_b.push_back(edge_cnt);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        ena = 1'b0;
        enb = 1'b0;
        wea = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
        ena   = 1'b1;
        enb   = 1'b0;
        addra = a;
        dina  = d;
        wea   = we;
        @(negedge clk);
        $display("write addr=%0d data=%h wea=%b", a, d, we);
        ena = 1'b0;
        wea = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb);
        ena   = 1'b0;
        enb   = 1'b1;
        addrb = a;
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        @(negedge clk);
        $display("read  addr=%0d expect_a=%h expect_b=%h", a, ea, eb);
        enb = 1'b0;
    endtask

    task automatic coll(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we,
                        input logic [31:0] ea, input logic [31:0] eb);
        ena   = 1'b1;
        enb   = 1'b1;
        addra = a;
        addrb = a;
        dina  = d;
        wea   = we;
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        @(negedge clk);
        $display("coll  addr=%0d data=%h wea=%b expect_a=%h expect_b=%h", a, d, we, ea, eb);
        ena = 1'b0;
        enb = 1'b0;
        wea = 4'h0;
    endtask

    // Let the pipelines empty, then compare captured reads with expectations.
    task automatic drain(input string tag);
        int n;
        idle(4);
        check_eq($sformatf("%s valid_count_a", tag), got_a.size(), exp_a.size());
        check_eq($sformatf("%s valid_count_b", tag), got_b.size(), exp_b.size());
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s data_a[%0d]", tag, i), got_a[i], exp_a[i]);
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s data_b[%0d]", tag, i), got_b[i], exp_b[i]);
        got_a.delete();
        got_b.delete();
        exp_a.delete();
        exp_b.delete();
    endtask

    // Hold reset for two edges and check the reset state just after the second.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        ena   = 1'b0;
        enb   = 1'b0;
        wea   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq($sformatf("%s doutb_a", tag), doutb_a, 32'h0);
        check_eq($sformatf("%s doutb_b", tag), doutb_b, 32'h0);
        check_eq($sformatf("%s valid_a", tag), {31'h0, doutb_valid_a}, 32'h0);
        check_eq($sformatf("%s valid_b", tag), {31'h0, doutb_valid_b}, 32'h0);
        check_eq($sformatf("%s busy_a", tag), {31'h0, init_busy_a}, 32'h1);
        check_eq($sformatf("%s busy_b", tag), {31'h0, init_busy_b}, 32'h1);
        $display("reset %s done", tag);
        @(negedge clk);
    endtask

    // Release reset and count init_busy cycles; optionally poke the ports.
    task automatic run_init(input string tag, input logic poke);
        int cnt_a;
        int cnt_b;
        rst_n = 1'b1;
        if (poke) begin
            ena   = 1'b1;
            wea   = 4'hf;
            addra = 4'd5;
            dina  = 32'hdeadbeef;
            enb   = 1'b1;
            addrb = 4'd5;
        end
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            if (!init_busy_a && !init_busy_b) break;
            if (init_busy_a) cnt_a++;
            if (init_busy_b) cnt_b++;
            @(negedge clk);
        end
        ena = 1'b0;
        enb = 1'b0;
        wea = 4'h0;
        $display("init  %s busy_cycles_a=%0d busy_cycles_b=%0d", tag, cnt_a, cnt_b);
        check_eq($sformatf("%s busy_cycles_a", tag), cnt_a, 32'd16);
        check_eq($sformatf("%s busy_cycles_b", tag), cnt_b, 32'd16);
        check_eq($sformatf("%s no_valid_a", tag), got_a.size(), 32'd0);
        check_eq($sformatf("%s no_valid_b", tag), got_b.size(), 32'd0);
        got_a.delete();
        got_b.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        rst_n = 1'b0;
        ena   = 1'b0;
        enb   = 1'b0;
        wea   = 4'h0;
        addra = 4'h0;
        addrb = 4'h0;
        dina  = 32'h0;

        // Reset, clear, and port activity during the clear.
        do_reset("reset1");
        run_init("init1", 1'b1);
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, 32'h0);
        drain("clear");

        // Sequential write then back-to-back reads, with latency check.
        wr(4'd0, 32'h01234567, 4'hf);
        wr(4'd1, 32'h89abcdef, 4'hf);
        wr(4'd2, 32'h10111213, 4'hf);
        wr(4'd3, 32'h14151617, 4'hf);
        edge_a.delete();
        edge_b.delete();
        acc = edge_cnt + 1;
        rd(4'd0, 32'h01234567, 32'h01234567);
        rd(4'd1, 32'h89abcdef, 32'h89abcdef);
        rd(4'd2, 32'h10111213, 32'h10111213);
        rd(4'd3, 32'h14151617, 32'h14151617);
        drain("seq");
        check_eq("latency_a", (edge_a.size() > 0) ? edge_a[0] - acc : -1, 32'd1);
        check_eq("latency_b", (edge_b.size() > 0) ? edge_b[0] - acc : -1, 32'd2);

        // Byte enables, and a write with no lanes enabled.
        wr(4'd1, 32'hffffffff, 4'b0101);
        rd(4'd1, 32'h89ffcdff, 32'h89ffcdff);
        wr(4'd3, 32'h00000000, 4'b0000);
        rd(4'd3, 32'h14151617, 32'h14151617);
        drain("byte_en");

        // Full-word collision, then a follow-up read of the written word.
        coll(4'd2, 32'haabbccdd, 4'hf, 32'h10111213, 32'haabbccdd);
        rd(4'd2, 32'haabbccdd, 32'haabbccdd);
        drain("coll_full");

        // Partial-lane collision.
        wr(4'd2, 32'h10111213, 4'hf);
        coll(4'd2, 32'haabbccdd, 4'b0011, 32'h10111213, 32'h1011ccdd);
        rd(4'd2, 32'h1011ccdd, 32'h1011ccdd);
        drain("coll_part");

        // Reset one edge after a read is accepted.
        ena   = 1'b0;
        enb   = 1'b1;
        addrb = 4'd0;
        @(negedge clk);
        $display("read  addr=0 then reset (no result expected)");
        enb = 1'b0;
        do_reset("reset2");
        run_init("init2", 1'b0);
        for (int i = 0; i < 4; i++) rd(4'(i), 32'h0, 32'h0);
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/simple_dual_pipe.md
# simple_dual_pipe

Parametrised single-clock simple dual-port RAM: one write port (A) with per-byte write enables and one read port (B). It adds configurable read latency, a read-valid output, selectable read/write collision behaviour and a post-reset memory-clear sequencer. It replaces fixed-size dual-clock RAM instances where both ports run in one clock domain and the datapath needs a qualified read strobe and known memory contents after reset.

## Interface

Parameters:
- `WIDTH`, 32, data word width; must be a multiple of 8.
- `ADDR_WIDTH`, 4, address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `WEA_WIDTH`, `WIDTH/8`, number of byte-lane write enables; not independently settable.
- `RD_LATENCY`, 1, read latency in cycles; legal values are 1 and 2.
- `COLL_MODE`, 0, same-address collision behaviour: 0 = read-first (old data), 1 = write-first (per-byte merged new data).
- `INIT_ON_RESET`, 1, 1 = clear all words to 0 after reset; 0 = no clear.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ena` in 1: port A enable.
- `wea` in `WEA_WIDTH`: byte write enables; `wea[i]` controls `dina[8i+7:8i]`.
- `addra` in `ADDR_WIDTH`: write address.
- `dina` in `WIDTH`: write data.
- `enb` in 1: read request.
- `addrb` in `ADDR_WIDTH`: read address.
- `doutb` out `WIDTH`: read data.
- `doutb_valid` out 1: `doutb` carries the result of a read accepted `RD_LATENCY` edges earlier.
- `init_busy` out 1: clear sequence in progress; ports ignored.

## Operation

- FSM states:
  - INIT: entered at reset when `INIT_ON_RESET=1`. A counter walks 0..DEPTH-1, writing 0 to one word per cycle. On the edge that writes `DEPTH-1`, the FSM moves to RUN.
  - RUN: normal operation.
  - With `INIT_ON_RESET=0`, reset goes directly to RUN and memory contents are undefined.
- In INIT, `ena` and `enb` are ignored: no writes, no reads, and `doutb_valid` is 0.
- Write: on an edge with `ena=1` in RUN, each byte lane whose `wea` bit is set is stored. `ena=1` with `wea=0` writes nothing.
- Read: on an edge with `enb=1` in RUN, the read is accepted. Port B does not depend on `ena`.
- Collision: `ena=1`, `enb=1`, `addra==addrb` on the same edge.
  - `COLL_MODE=0`: the read returns the pre-write word.
  - `COLL_MODE=1`: the read returns a per-lane merge, with `dina` in enabled lanes and the old word elsewhere.
  - Memory always receives the write.
- `doutb` holds its last value when no read completes. `doutb_valid` is high for exactly one cycle per accepted read.
- Back-to-back reads, one per cycle, are fully pipelined at either latency.

## Timing

- Reset (`rst_n=0` sampled at an edge):
  - `doutb`=0, `doutb_valid`=0.
  - `init_busy`=1 if `INIT_ON_RESET` else 0.
  - The read pipeline is flushed and the INIT counter is set to 0.
- Reset asserted mid-operation discards in-flight reads (no `doutb_valid`) and restarts INIT from address 0.
- `init_busy` is 1 for exactly DEPTH cycles after the first edge with `rst_n=1`, then 0.
- The first legal access is on the edge following `init_busy` falling.
- A read accepted at edge k gives `doutb`/`doutb_valid` updated at:
  - edge k+1 for `RD_LATENCY=1`;
  - edge k+2 for `RD_LATENCY=2` (output register stage).
- A write at edge k is visible to a non-colliding read accepted at edge k+1 or later.

## Test plan

- **Reset and clear** (`WIDTH=32`, `ADDR_WIDTH=4`): hold `rst_n` low for 2 cycles, then release → `init_busy` high exactly 16 cycles. Then read addresses 0..15 → every word is 0x00000000 and `doutb_valid` pulses 16 times.
- **Sequential write/read:**
  - Write addr 0..3 = 0x01234567, 0x89abcdef, 0x10111213, 0x14151617 with `wea=4'hf`, then read 0..3 back to back → same values in order.
  - `doutb_valid` first rises 1 edge after the first read (`RD_LATENCY=1`), or 2 edges after it (`RD_LATENCY=2`).
- **Byte enables:** with addr 1 = 0x89abcdef, write 0xffffffff with `wea=4'b0101` → read returns 0x89ffcdff.
- **Collision:** with addr 2 = 0x10111213, issue a same-edge write of 0xaabbccdd (`wea=4'hf`) and a read of addr 2.
  - `COLL_MODE=0` → 0x10111213, and the next read returns 0xaabbccdd.
  - `COLL_MODE=1` → 0xaabbccdd.
  - `COLL_MODE=1` with `wea=4'b0011` → 0x1011ccdd.
- **Access during INIT:** assert `ena=1`, `addra=5`, `dina=0xdeadbeef` and `enb=1` while `init_busy=1` → no `doutb_valid` during INIT, and addr 5 reads 0x00000000 after INIT.
- **Reset mid-read** (`RD_LATENCY=2`): drop `rst_n` one edge after a read is accepted → `doutb_valid` never asserts for it, `doutb`=0, and INIT reruns for 16 cycles, leaving previously written words at 0.
